// File: rtl/dmem_dma_copier.sv
`default_nettype none
// ============================================================================
// Module   : dmem_dma_copier
// Function : Data-memory DMA engine for block copy (memory to memory) and
//            block fill (constant to memory). It shares the data-memory port
//            with the CPU through a bus_req/bus_grant handshake.
// Option   : define DMEM_DMA_CHECKSUM_EN to add a modular sum of written bytes
// Revision : 1.0 - initial release
// ============================================================================
module dmem_dma_copier #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] length,
    input  logic [DW-1:0] fill_data,
    output logic          bus_req,
    input  logic          bus_grant,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_rdata,
`ifdef DMEM_DMA_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_mode;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_rem;
    logic [DW-1:0] r_fill;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_addr_q;
    logic [DW-1:0] r_wdata_q;

    logic          w_accept;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_last;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_rd_fire = (r_state == ST_READ) && bus_grant;
    assign w_wr_fire = (r_state == ST_WRITE) && bus_grant;
    assign w_last    = (r_rem == AW'(1));

    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address and write data hold their last driven value outside READ/WRITE
    always_comb begin
        w_next_state = r_state;
        bus_req      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        mem_rw       = 1'b0;
        w_addr       = r_addr_q;
        w_wdata      = r_wdata_q;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (length == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_grant) begin
                    w_next_state = r_mode ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                w_addr  = r_src;
                if (bus_grant) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                w_addr  = r_dst;
                w_wdata = r_mode ? r_fill : r_data;
                // Gated by grant so the engine never writes while not owning the port
                mem_rw  = bus_grant;
                if (bus_grant) begin
                    if (w_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = r_mode ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_fill    <= '0;
            r_data    <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            r_addr_q  <= w_addr;
            r_wdata_q <= w_wdata;
            if (w_accept && (length != '0)) begin
                r_mode <= mode;
                r_src  <= src_addr;
                r_dst  <= dst_addr;
                r_rem  <= length;
                r_fill <= fill_data;
            end
            if (w_rd_fire) begin
                r_data <= mem_rdata;
                r_src  <= r_src + AW'(1);
            end
            if (w_wr_fire) begin
                r_dst <= r_dst + AW'(1);
                r_rem <= r_rem - AW'(1);
            end
        end
    end

`ifdef DMEM_DMA_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_wr_fire) begin
            r_checksum <= r_checksum + w_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_dma_copier.md
Name: dmem_dma_copier

Overview:
- Bus-initiator engine that drives the data-memory port (address, write data, read/write select) and consumes its combinational read data.
- Performs block copy (memory to memory) or block fill (constant to memory) without CPU involvement.
- Sits beside the CPU and shares the data-memory port with it through a req/grant handshake. The external arbiter muxes the port based on bus_grant.

Parameters:
AW, 8, address width; also the width of src_addr, dst_addr and length.
DW, 8, data width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle start pulse; sampled only in IDLE.
mode  input  1  0 = copy, 1 = fill; latched on accepted start.
src_addr  input  AW  copy source base; latched on start.
dst_addr  input  AW  destination base; latched on start.
length  input  AW  byte count 0..2^AW-1; latched on start.
fill_data  input  DW  fill constant; latched on start.
bus_req  output  1  requests ownership of the data-memory port.
bus_grant  input  1  arbiter grant; the engine owns the port while it is high.
mem_addr  output  AW  memory address.
mem_wdata  output  DW  memory write data.
mem_rw  output  1  0 = read, 1 = write; matches the data-memory encoding.
mem_rdata  input  DW  combinational read data for mem_addr.
busy  output  1  transfer in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: bus_req, mem_addr, mem_wdata, mem_rw, busy, done.
  - All internal registers 0.
  - A reset mid-transfer aborts immediately. mem_rw goes 0 asynchronously, no done pulse, partial writes remain.
- FSM states: IDLE, REQ, READ, WRITE, DONE.
- IDLE:
  - start=1 and length!=0: latch all inputs; next state REQ.
  - start=1 and length=0: next state DONE. No bus_req, no memory access.
- REQ: bus_req=1. Moves on bus_grant=1: to READ for copy, to WRITE for fill.
- READ:
  - mem_addr=src pointer, mem_rw=0.
  - At the clock edge with bus_grant=1: capture mem_rdata into the data register, increment src, next state WRITE.
- WRITE:
  - mem_addr=dst pointer, mem_wdata = data register (copy) or fill_data (fill).
  - mem_rw = bus_grant (combinational gate). No write is ever issued without grant.
  - At the edge with bus_grant=1: increment dst, decrement the remaining count.
  - Remaining count reaches 0: next state DONE. Otherwise next state READ (copy) or WRITE (fill).
- DONE: done=1 for exactly one cycle; next state IDLE.
- busy=1 in REQ/READ/WRITE/DONE. bus_req=1 in REQ/READ/WRITE.
- Stall: if bus_grant=0 in READ or WRITE, state, pointers, count and data register all hold, and mem_rw=0. The transfer resumes from the same byte when grant returns.
- Pointers wrap modulo 2^AW (0xFF+1 -> 0x00). No overlap detection; overlapping copies proceed with ascending addresses.
- start while busy is ignored; no queueing.
- Latency with grant tied high:
  - copy: 1 (REQ) + 2N + 1 (DONE) cycles from the accepted start.
  - fill: 1 + N + 1 cycles.
- mem_addr and mem_wdata hold their last driven values in IDLE/DONE. mem_rw=0 outside WRITE.

Optional Feature:
- Macro: DMEM_DMA_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DW-1:0], an 8-bit modular sum of every byte actually written (granted WRITE edges).
  - Cleared on an accepted start; held stable from DONE until the next start; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-copy: assert rst_n=0 during WRITE -> mem_rw=0 immediately; all outputs 0; state IDLE; no done pulse.
- Copy with grant high:
  - Stimulus: preload mem[0x10..0x13]=A1,B2,C3,D4; start copy src=0x10 dst=0x80 len=4.
  - Response: mem[0x80..0x83]=A1,B2,C3,D4; done pulse exactly 10 cycles after start; busy low the following cycle.
- Fill with wrap:
  - Stimulus: fill dst=0xFE len=3 data=0x5A.
  - Response: mem[0xFE], mem[0xFF], mem[0x00]=5A; mem[0x01] untouched; done at cycle 5.
- Grant stall: copy len=2 with bus_grant=0 for 3 cycles during the first WRITE -> mem_rw=0 during the stall; no extra or duplicate writes; final data correct; done at cycle 9 (6+3).
- Zero length and busy start:
  - start len=0 -> done on the next cycle; bus_req never asserted; no memory access.
  - start pulsed while busy -> ignored; the original transfer completes unchanged.
- With DMEM_DMA_CHECKSUM_EN: copy of bytes 0xF0,0x20,0x01 -> checksum=0x11 at done; it holds until the next start, then clears to 0.
